// File: rtl/cic_integrator_chain_pkg.sv
// cic_integrator_chain_pkg: shared oversampling constants, os_sel encoding and effective-width helper
package cic_integrator_chain_pkg;
  localparam int OS_MAX_LOG2 = 6;
  typedef enum logic [2:0] {OS_1, OS_2, OS_4, OS_8, OS_16, OS_32, OS_64, OS_INVALID} os_sel_e;
  function automatic int ew_of(input int idw, input int stages, input int l);
    return idw + stages * l;
  endfunction
endpackage

// File: rtl/cic_integ_stage.sv
// cic_integ_stage: one CIC integrator (accumulator with wrap/saturate at effective width, sticky overflow flag)
//   clk (falling edge), reset (async high); flush_i clears acc/valid; hold_i freezes the stage;
//   valid_i/add_i: addend and its qualifier; l_i: log2 oversampling; valid_o/acc_o: registered result;
//   ovf_flag_o: sticky overflow, cleared by clr_flag_i; ovf_sign_o: sign of the latest overflowing sum.
module cic_integ_stage
  import cic_integrator_chain_pkg::*;
#(
  parameter int IDW    = 16,
  parameter int STAGES = 3,
  parameter int ODW    = 36
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush_i,
  input  logic           hold_i,
  input  logic           valid_i,
  input  logic           sat_en_i,
  input  logic           clr_flag_i,
  input  logic [2:0]     l_i,
  input  logic [ODW-1:0] add_i,
  output logic           valid_o,
  output logic [ODW-1:0] acc_o,
  output logic           ovf_flag_o,
  output logic           ovf_sign_o
);
  localparam int SW = ODW + 1;
  logic valid_q, valid_d, flag_q, flag_d, sign_q, sign_d, upd, ovf;
  logic [ODW-1:0] acc_q, acc_d;
  logic signed [SW-1:0] sum, lim, wrap, res;
  int ew;
  always_comb begin
    ew = ew_of(IDW, STAGES, int'(l_i));
    sum = $signed({acc_q[ODW-1], acc_q}) + $signed({add_i[ODW-1], add_i});
    lim = SW'(1) << (ew - 1);
    ovf = sum >= lim || sum < -lim;
    // shift the EW-bit field to the top and back down to sign-extend it (modulo 2^EW)
    wrap = (sum <<< (SW - ew)) >>> (SW - ew);
    res = !ovf ? sum : sat_en_i ? (sum[SW-1] ? -lim : lim - SW'(1)) : wrap;
    upd = valid_i && !hold_i && !flush_i;
    acc_d = flush_i ? '0 : upd ? res[ODW-1:0] : acc_q;
    valid_d = flush_i ? 1'b0 : hold_i ? valid_q : valid_i;
    flag_d = (flag_q && !clr_flag_i) || (upd && ovf);
    sign_d = (upd && ovf) ? sum[SW-1] : sign_q;
  end
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      valid_q <= 1'b0;
      flag_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      valid_q <= valid_d;
      flag_q <= flag_d;
      sign_q <= sign_d;
    end
  end
  assign valid_o = valid_q;
  assign acc_o = acc_q;
  assign ovf_flag_o = flag_q;
  assign ovf_sign_o = sign_q;
endmodule

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: cascaded CIC integrators with decimation-frame strobe and per-stage overflow flags
//   clk (falling edge), reset (async high); os_sel: log2 oversampling 0..6, 7 invalid (cfg_err);
//   sat_en: saturate vs wrap; in_valid/data_in: input samples; clr_flags: clear sticky flags;
//   out_valid/data_out: last-stage result; dec_strobe: last sample of a 2^L frame; ovf_flag/ovf_sign per stage.
module cic_integrator_chain
  import cic_integrator_chain_pkg::*;
#(
  parameter int IDW    = 16,
  parameter int STAGES = 3,
  parameter int ODW    = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        os_sel,
  input  logic              sat_en,
  input  logic              in_valid,
  input  logic [IDW-1:0]    data_in,
  input  logic              clr_flags,
  output logic              out_valid,
  output logic [ODW-1:0]    data_out,
  output logic              dec_strobe,
  output logic [STAGES-1:0] ovf_flag,
  output logic [STAGES-1:0] ovf_sign,
  output logic              cfg_err
);
  if (STAGES < 1 || STAGES > 6 || ODW < IDW + OS_MAX_LOG2 * STAGES) begin : g_bad_cfg
    $error("cic_integrator_chain: STAGES must be 1..6 and ODW >= IDW+6*STAGES");
  end
  logic [2:0] os_q, l;
  logic armed_q, flush;
  logic [5:0] cnt_q, cnt_d, mask;
  logic v [STAGES+1];
  logic [ODW-1:0] a [STAGES+1];
  assign cfg_err = os_sel == OS_INVALID;
  // armed_q suppresses a spurious flush on the first edge after reset
  assign flush = armed_q && os_sel != os_q;
  assign l = cfg_err ? 3'd0 : os_sel;
  assign mask = ~(6'h3f << l);
  assign v[0] = in_valid;
  assign a[0] = {{(ODW-IDW){data_in[IDW-1]}}, data_in};
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cic_integ_stage #(.IDW(IDW), .STAGES(STAGES), .ODW(ODW)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush),
      .hold_i     (cfg_err),
      .valid_i    (v[i]),
      .sat_en_i   (sat_en),
      .clr_flag_i (clr_flags),
      .l_i        (l),
      .add_i      (a[i]),
      .valid_o    (v[i+1]),
      .acc_o      (a[i+1]),
      .ovf_flag_o (ovf_flag[i]),
      .ovf_sign_o (ovf_sign[i])
    );
  end
  assign out_valid = v[STAGES] && !cfg_err;
  assign data_out = a[STAGES];
  assign dec_strobe = out_valid && cnt_q == mask;
  assign cnt_d = flush ? '0 : !out_valid ? cnt_q : cnt_q == mask ? '0 : cnt_q + 6'd1;
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      os_q <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      os_q <= os_sel;
      armed_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cic_integrator_chain.sv
// tb_cic_integrator_chain: randomized stimulus against an arithmetic reference model of the CIC chain
module tb_cic_integrator_chain;
  localparam int IDW = 16, S = 3, ODW = 36;
  logic clk = 1'b1, reset = 1'b1, sat_en = 1'b0, in_valid = 1'b0, clr_flags = 1'b0;
  logic [2:0] os_sel = 3'd2;
  logic [IDW-1:0] data_in = '0;
  logic out_valid, dec_strobe, cfg_err;
  logic [ODW-1:0] data_out;
  logic [S-1:0] ovf_flag, ovf_sign;
  int checks = 0, errors = 0;
  longint m_acc [S];
  bit m_v [S], m_flag [S], m_sign [S];
  int m_cnt;
  bit m_armed;
  logic [2:0] m_os;

  always #5 clk = ~clk;

  cic_integrator_chain #(.IDW(IDW), .STAGES(S), .ODW(ODW)) dut (
    .clk(clk), .reset(reset), .os_sel(os_sel), .sat_en(sat_en), .in_valid(in_valid),
    .data_in(data_in), .clr_flags(clr_flags), .out_valid(out_valid), .data_out(data_out),
    .dec_strobe(dec_strobe), .ovf_flag(ovf_flag), .ovf_sign(ovf_sign), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic longint fold(input longint s, input int ew, input bit sat, output bit ovf);
    longint lim = longint'(1) << (ew - 1);
    longint m = longint'(1) << ew;
    longint r;
    ovf = s >= lim || s < -lim;
    if (!ovf) return s;
    if (sat) return s < 0 ? -lim : lim - 1;
    r = s % m;
    if (r < 0) r += m;
    if (r >= lim) r -= m;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_acc[k] = 0; m_v[k] = 0; m_flag[k] = 0; m_sign[k] = 0;
    end
    m_cnt = 0;
    m_armed = 0;
  endtask

  task automatic model_step();
    bit cfg = os_sel == 3'd7;
    int lg = cfg ? 0 : int'(os_sel);
    int ew = IDW + S * lg;
    bit fl = m_armed && os_sel != m_os;
    if (fl) m_cnt = 0;
    else if (m_v[S-1] && !cfg) m_cnt = (m_cnt + 1) % (1 << lg);
    for (int k = S - 1; k >= 0; k--) begin
      bit vin = k == 0 ? in_valid : m_v[k-1];
      longint add = k == 0 ? longint'($signed(data_in)) : m_acc[k-1];
      longint s = m_acc[k] + add;
      bit o = 0;
      if (fl) begin
        m_acc[k] = 0; m_v[k] = 0;
      end else if (!cfg) begin
        if (vin) m_acc[k] = fold(s, ew, sat_en, o);
        m_v[k] = vin;
      end
      m_flag[k] = (m_flag[k] && !clr_flags) || o;
      if (o) m_sign[k] = s < 0;
    end
    m_os = os_sel;
    m_armed = 1;
  endtask

  task automatic expect_outputs();
    bit cfg = os_sel == 3'd7;
    int lg = cfg ? 0 : int'(os_sel);
    bit ov = m_v[S-1] && !cfg;
    logic [S-1:0] ef, es;
    for (int k = 0; k < S; k++) begin
      ef[k] = m_flag[k]; es[k] = m_sign[k];
    end
    check("out_valid", 64'(out_valid), 64'(ov));
    check("data_out", {{(64-ODW){data_out[ODW-1]}}, data_out}, m_acc[S-1]);
    check("dec_strobe", 64'(dec_strobe), 64'(ov && m_cnt == (1 << lg) - 1));
    check("ovf_flag", 64'(ovf_flag), 64'(ef));
    check("ovf_sign", 64'(ovf_sign), 64'(es));
    check("cfg_err", 64'(cfg_err), 64'(cfg));
  endtask

  task automatic step(input logic [2:0] os, input bit s, input bit iv, input logic [IDW-1:0] d, input bit c);
    os_sel = os; sat_en = s; in_valid = iv; data_in = d; clr_flags = c;
    model_step();
    @(posedge clk);
    #1;
    expect_outputs();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    expect_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    bit s;
    model_reset();
    @(posedge clk);
    #1;
    expect_outputs();
    os_sel = 3'd7;
    #1;
    check("rst_cfg_err", 64'(cfg_err), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    os_sel = 3'd2;
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) step(3'd2, 0, 1, 16'd1, 0);
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) s = 1'($urandom);
      step(3'd2, s, $urandom_range(3) != 0, 16'($urandom), $urandom_range(15) == 0);
    end
    for (int i = 0; i < 40; i++) step(3'd1, 1, 1, 16'h7fff, 0);
    check("sat_top", 64'(data_out), 64'd262143);
    check("sat_flag2", 64'(ovf_flag[2]), 64'd1);
    check("sat_sign2", 64'(ovf_sign[2]), 64'd0);
    for (int i = 0; i < 4; i++) step(3'd1, 1, 0, 16'h7fff, 0);
    step(3'd1, 1, 0, 16'h7fff, 1);
    step(3'd1, 1, 1, 16'h7fff, 1);
    for (int i = 0; i < 5; i++) step(3'd1, 1, 1, 16'h7fff, 0);
    pulse_reset();
    for (int i = 0; i < 40; i++) step(3'd1, 0, 1, 16'h7fff, 0);
    for (int i = 0; i < 10; i++) step(3'd2, 0, 1, 16'($urandom_range(255)), 0);
    for (int i = 0; i < 40; i++) step(3'd4, 0, 1, 16'($urandom_range(255)), 0);
    for (int i = 0; i < 6; i++) step(3'd7, 0, 1, 16'($urandom), 0);
    for (int i = 0; i < 20; i++) step(3'd3, 0, 1, 16'($urandom), 0);
    for (int i = 0; i < 12; i++) step(3'd0, 0, $urandom_range(1) == 1, 16'($urandom), 0);
    for (int g = 0; g < 20; g++) begin
      logic [2:0] os = 3'($urandom_range(7));
      int len = $urandom_range(25, 5);
      s = 1'($urandom);
      if (g == 10) pulse_reset();
      for (int i = 0; i < len; i++)
        step(os, s, $urandom_range(3) != 0, 16'($urandom), $urandom_range(15) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
